// File: rtl/mem_loader_if.sv
// mem_loader_if -- byte-stream handshake and data-memory bus of mem_loader.
//   byte_in        : incoming data byte (source -> loader)
//   byte_valid     : byte present (source -> loader)
//   byte_ready     : loader can take a byte (loader -> source)
//   mem_address    : word-aligned byte address (loader -> memory)
//   mem_write_data : word to store (loader -> memory)
//   mem_write      : write enable (loader -> memory)
//   mem_read_data  : readback word, memory clocked on the inverted clock
// Modports: master = loader side, slave = source/memory side.
interface mem_loader_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic [31:0] mem_read_data;

  modport master (
    input  byte_in, byte_valid, mem_read_data,
    output byte_ready, mem_address, mem_write_data, mem_write
  );

  modport slave (
    output byte_in, byte_valid, mem_read_data,
    input  byte_ready, mem_address, mem_write_data, mem_write
  );
endinterface

// File: rtl/mem_loader.sv
// mem_loader -- assembles a little-endian byte stream into 32-bit words and
// writes them to consecutive word addresses starting at BASE_ADDR.
// Optional readback check enabled by defining macro LOADER_VERIFY_EN.
// Ports:
//   clock      : system clock, all state on rising edge
//   reset      : asynchronous active-high reset
//   start      : load request, sampled only in IDLE
//   word_count : number of words to load, captured with start
//   bus        : byte handshake + memory bus (mem_loader_if.master)
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse at end of load
//   error      : sticky readback-mismatch flag (0 without LOADER_VERIFY_EN)
module mem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [13:0]       word_count,
  mem_loader_if.master      bus,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [31:0] BASE = {BASE_ADDR[31:2], 2'b00};

`ifdef LOADER_VERIFY_EN
  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_VERIFY, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;
`endif

  state_t      r_state, w_next;
  logic [1:0]  r_lane;
  logic [13:0] r_index;
  logic [13:0] r_count;
  logic [31:0] r_checksum;
  logic [23:0] r_shift;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic        w_byte_ready;
  logic        w_mem_write;
  logic        w_accept;
  logic        w_last_word;

`ifdef LOADER_VERIFY_EN
  logic [13:0] r_vidx;
  logic [31:0] r_rsum;
  logic        r_error;
  logic        w_last_verify;
  logic [31:0] w_rsum_next;

  assign w_last_verify = (r_vidx == (r_count - 14'd1));
  // read data for the address driven this cycle is valid at the closing edge
  assign w_rsum_next   = r_rsum + bus.mem_read_data;
  assign error         = r_error;
`else
  assign error = 1'b0;
`endif

  assign w_accept    = (r_state == S_COLLECT) && bus.byte_valid;
  assign w_last_word = ((r_index + 14'd1) == r_count);

  assign bus.byte_ready     = w_byte_ready;
  assign bus.mem_write      = w_mem_write;
  assign bus.mem_address    = r_addr;
  assign bus.mem_write_data = r_wdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_byte_ready = 1'b0;
    w_mem_write  = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = (word_count == 14'd0) ? S_DONE : S_COLLECT;
      end
      S_COLLECT: begin
        w_byte_ready = 1'b1;
        if (bus.byte_valid && (r_lane == 2'd3)) w_next = S_WRITE;
      end
      S_WRITE: begin
        w_mem_write = 1'b1;
`ifdef LOADER_VERIFY_EN
        w_next = w_last_word ? S_VERIFY : S_COLLECT;
`else
        w_next = w_last_word ? S_DONE : S_COLLECT;
`endif
      end
`ifdef LOADER_VERIFY_EN
      S_VERIFY: begin
        if (w_last_verify) w_next = S_DONE;
      end
`endif
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Lanes 0..2 are staged in r_shift so the bus outputs only change when a
  // complete word is handed to WRITE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lane     <= '0;
      r_index    <= '0;
      r_count    <= '0;
      r_checksum <= '0;
      r_shift    <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
`ifdef LOADER_VERIFY_EN
      r_vidx     <= '0;
      r_rsum     <= '0;
      r_error    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_count    <= word_count;
            r_index    <= '0;
            r_checksum <= '0;
            r_lane     <= '0;
`ifdef LOADER_VERIFY_EN
            r_error    <= 1'b0;
`endif
          end
        end
        S_COLLECT: begin
          if (w_accept) begin
            r_lane <= r_lane + 2'd1;
            case (r_lane)
              2'd0: r_shift[7:0]   <= bus.byte_in;
              2'd1: r_shift[15:8]  <= bus.byte_in;
              2'd2: r_shift[23:16] <= bus.byte_in;
              default: begin
                r_wdata <= {bus.byte_in, r_shift};
                r_addr  <= BASE + {16'd0, r_index, 2'b00};
              end
            endcase
          end
        end
        S_WRITE: begin
          r_checksum <= r_checksum + r_wdata;
          r_index    <= r_index + 14'd1;
`ifdef LOADER_VERIFY_EN
          if (w_last_word) begin
            r_addr <= BASE;
            r_vidx <= '0;
            r_rsum <= '0;
          end
`endif
        end
`ifdef LOADER_VERIFY_EN
        S_VERIFY: begin
          r_rsum <= w_rsum_next;
          if (w_last_verify) begin
            r_error <= (w_rsum_next != r_checksum);
          end else begin
            r_vidx <= r_vidx + 14'd1;
            r_addr <= r_addr + 32'd4;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
module tb_mem_loader;

`ifdef LOADER_VERIFY_EN
  localparam int VERIFY = 1;
`else
  localparam int VERIFY = 0;
`endif

  logic        clock;
  logic        reset;
  logic        start;
  logic [13:0] word_count;
  logic        busy, done, error;

  mem_loader_if bus();

  mem_loader #(.BASE_ADDR(32'h0000_0000)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  int checks   = 0;
  int failures = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // memory model on inverted clock, with write log and optional corruption
  logic [31:0] mem [0:16383];
  logic [31:0] wr_a [0:63];
  logic [31:0] wr_d [0:63];
  int          wr_n = 0;
  logic        corrupt = 1'b0;
  logic [31:0] rd_q = '0;

  assign bus.mem_read_data = rd_q;

  always @(negedge clock) begin
    if (bus.mem_write === 1'b1) begin
      mem[bus.mem_address[15:2]] <= bus.mem_write_data;
      if (wr_n < 64) begin
        wr_a[wr_n] = bus.mem_address;
        wr_d[wr_n] = bus.mem_write_data;
      end
      wr_n++;
    end
    if (corrupt && bus.mem_address[15:2] == 14'd1)
      rd_q <= mem[bus.mem_address[15:2]] ^ 32'h0000_0100;
    else
      rd_q <= mem[bus.mem_address[15:2]];
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [13:0] n);
    start      = 1'b1;
    word_count = n;
    tick();
    start      = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    while (!bus.byte_ready && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL send_byte_timeout got=no_ready exp=ready byte=%h", b);
    end
    tick();
    bus.byte_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; word_count = '0;
    bus.byte_in = '0; bus.byte_valid = 1'b0;
    #1;
    checks++;
    if ({busy, done, error, bus.mem_write, bus.byte_ready} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00000",
               {busy, done, error, bus.mem_write, bus.byte_ready});
    end
    checks++;
    if (bus.mem_address !== 32'h0 || bus.mem_write_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_bus got=%h/%h exp=0/0", bus.mem_address, bus.mem_write_data);
    end
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int n0, cyc;
    n0 = wr_n;
    do_start(14'd1);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    checks++;
    if (bus.mem_write !== 1'b1 || bus.mem_address !== 32'h0 || bus.mem_write_data !== 32'h1234_5678) begin
      failures++;
      $display("FAIL single_write got=%b/%h/%h exp=1/00000000/12345678",
               bus.mem_write, bus.mem_address, bus.mem_write_data);
    end
    wait_done(cyc);
    checks++;
    if (cyc != 1 + VERIFY) begin
      failures++;
      $display("FAIL single_done_latency got=%0d exp=%0d", cyc, 1 + VERIFY);
    end
    checks++;
    if (error !== 1'b0) begin
      failures++;
      $display("FAIL single_error got=%b exp=0", error);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_idle got=done%b busy%b exp=done0 busy0", done, busy);
    end
    checks++;
    if (wr_n - n0 != 1) begin
      failures++;
      $display("FAIL single_write_count got=%0d exp=1", wr_n - n0);
    end
  endtask

  task automatic test_toggle();
    int n0, cyc, k;
    logic v, rdy;
    logic [31:0] exp_d [3];
    exp_d[0] = 32'h0403_0201; exp_d[1] = 32'h0807_0605; exp_d[2] = 32'h0C0B_0A09;
    n0 = wr_n;
    do_start(14'd3);
    k = 0; cyc = 0;
    while (k < 12 && cyc < 300) begin
      v = (cyc % 2 == 0);
      bus.byte_valid = v;
      bus.byte_in    = 8'(k + 1);
      rdy = bus.byte_ready;
      tick();
      if (v && rdy) k++;
      cyc++;
    end
    bus.byte_valid = 1'b0;
    checks++;
    if (k != 12) begin
      failures++;
      $display("FAIL toggle_bytes got=%0d exp=12", k);
    end
    wait_done(cyc);
    checks++;
    if (cyc != 1 + 3 * VERIFY) begin
      failures++;
      $display("FAIL toggle_done_latency got=%0d exp=%0d", cyc, 1 + 3 * VERIFY);
    end
    checks++;
    if (wr_n - n0 != 3) begin
      failures++;
      $display("FAIL toggle_write_count got=%0d exp=3", wr_n - n0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wr_a[n0 + i] !== 32'(4 * i) || wr_d[n0 + i] !== exp_d[i]) begin
          failures++;
          $display("FAIL toggle_word%0d got=%h/%h exp=%h/%h", i,
                   wr_a[n0 + i], wr_d[n0 + i], 32'(4 * i), exp_d[i]);
        end
      end
    end
    checks++;
    if (error !== 1'b0) begin
      failures++;
      $display("FAIL toggle_error got=%b exp=0", error);
    end
    tick();
  endtask

  task automatic test_zero();
    int n0;
    n0 = wr_n;
    do_start(14'd0);
    checks++;
    if (busy !== 1'b1 || done !== 1'b1) begin
      failures++;
      $display("FAIL zero_done got=busy%b done%b exp=busy1 done1", busy, done);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL zero_idle got=busy%b done%b exp=busy0 done0", busy, done);
    end
    checks++;
    if (wr_n != n0) begin
      failures++;
      $display("FAIL zero_writes got=%0d exp=0", wr_n - n0);
    end
  endtask

  task automatic test_reset_mid();
    int n0, cyc;
    n0 = wr_n;
    do_start(14'd4);
    for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i));
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, error, bus.mem_write, bus.byte_ready} !== 5'b0 ||
        bus.mem_address !== 32'h0 || bus.mem_write_data !== 32'h0) begin
      failures++;
      $display("FAIL midreset_outputs got=%b/%h/%h exp=00000/0/0",
               {busy, done, error, bus.mem_write, bus.byte_ready},
               bus.mem_address, bus.mem_write_data);
    end
    tick();
    reset = 1'b0;
    tick(); tick();
    checks++;
    if (wr_n - n0 != 1 || wr_a[n0] !== 32'h0 || wr_d[n0] !== 32'hA3A2_A1A0) begin
      failures++;
      $display("FAIL midreset_writes got=%0d %h/%h exp=1 00000000/a3a2a1a0",
               wr_n - n0, wr_a[n0], wr_d[n0]);
    end
    do_start(14'd1);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    checks++;
    if (bus.mem_write !== 1'b1 || bus.mem_address !== 32'h0 || bus.mem_write_data !== 32'h4433_2211) begin
      failures++;
      $display("FAIL midreset_reload got=%b/%h/%h exp=1/00000000/44332211",
               bus.mem_write, bus.mem_address, bus.mem_write_data);
    end
    wait_done(cyc);
    tick();
  endtask

  task automatic test_busy_start();
    int n0, cyc;
    n0 = wr_n;
    do_start(14'd2);
    send_byte(8'h01); send_byte(8'h02);
    start = 1'b1; word_count = 14'd1;
    tick();
    start = 1'b0;
    for (int i = 3; i <= 8; i++) send_byte(8'(i));
    wait_done(cyc);
    checks++;
    if (cyc != 1 + 2 * VERIFY) begin
      failures++;
      $display("FAIL busystart_latency got=%0d exp=%0d", cyc, 1 + 2 * VERIFY);
    end
    checks++;
    if (wr_n - n0 != 2 || wr_a[n0] !== 32'h0 || wr_a[n0 + 1] !== 32'h4 ||
        wr_d[n0] !== 32'h0403_0201 || wr_d[n0 + 1] !== 32'h0807_0605) begin
      failures++;
      $display("FAIL busystart_writes got=%0d %h/%h %h/%h exp=2 0/04030201 4/08070605",
               wr_n - n0, wr_a[n0], wr_d[n0], wr_a[n0 + 1], wr_d[n0 + 1]);
    end
    tick();
  endtask

`ifdef LOADER_VERIFY_EN
  task automatic test_verify();
    int cyc;
    corrupt = 1'b1;
    do_start(14'd2);
    for (int i = 0; i < 8; i++) send_byte(8'h50 + 8'(i));
    wait_done(cyc);
    checks++;
    if (cyc != 3 || error !== 1'b1) begin
      failures++;
      $display("FAIL verify_corrupt got=lat%0d err%b exp=lat3 err1", cyc, error);
    end
    tick();
    checks++;
    if (error !== 1'b1) begin
      failures++;
      $display("FAIL verify_sticky got=%b exp=1", error);
    end
    corrupt = 1'b0;
    do_start(14'd2);
    checks++;
    if (error !== 1'b0) begin
      failures++;
      $display("FAIL verify_clear_on_start got=%b exp=0", error);
    end
    for (int i = 0; i < 8; i++) send_byte(8'h50 + 8'(i));
    wait_done(cyc);
    checks++;
    if (cyc != 3 || error !== 1'b0) begin
      failures++;
      $display("FAIL verify_clean got=lat%0d err%b exp=lat3 err0", cyc, error);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_toggle();
    test_zero();
    test_reset_mid();
    test_busy_start();
`ifdef LOADER_VERIFY_EN
    test_verify();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 The parameter BASE_ADDR SHALL be 32-bit, default 32'h0000_0000, and set the byte address of the first loaded word; bits [1:0] SHALL be treated as zero.
REQ-002 The port clock SHALL be an input, 1 bit wide: the single system clock, with all state on its rising edge.
REQ-003 The port reset SHALL be an input, 1 bit wide: asynchronous, active-high reset.
REQ-004 The port start SHALL be an input, 1 bit wide: pulse that begins a load; sampled only in IDLE.
REQ-005 The port word_count SHALL be an input, 14 bits wide: number of 32-bit words to load, sampled when start is accepted.
REQ-006 The port byte_in SHALL be an input, 8 bits wide: incoming data byte.
REQ-007 The ports byte_valid (input, 1 bit) and byte_ready (output, 1 bit) SHALL form the byte handshake; a byte transfers on a rising edge where both are high.
REQ-008 The port mem_address SHALL be an output, 32 bits wide: word-aligned byte address to data memory; the memory uses bits [15:2].
REQ-009 The port mem_write_data SHALL be an output, 32 bits wide: word to be written.
REQ-010 The port mem_write SHALL be an output, 1 bit wide: memory write enable.
REQ-011 The port mem_read_data SHALL be an input, 32 bits wide: memory read data, valid at the rising edge after mem_address is driven (memory is clocked on the inverted clock).
REQ-012 The output busy SHALL be 1 bit, high in every state except IDLE.
REQ-013 The output done SHALL be 1 bit: a one-cycle pulse marking the end of a load.
REQ-014 The output error SHALL be 1 bit: sticky readback-mismatch flag.

Function
REQ-015 The FSM SHALL have the states IDLE, COLLECT, WRITE, VERIFY and DONE; VERIFY exists only under REQ-029.
REQ-016 IDLE SHALL go to COLLECT on start when word_count is non-zero, or to DONE when word_count is 0; when start is accepted, error SHALL clear and the word index and checksum SHALL reset to 0.
REQ-017 byte_ready SHALL be high only in COLLECT; byte_valid outside COLLECT SHALL be ignored.
REQ-018 The byte with lane k (0..3) SHALL be placed in mem_write_data[8k+7:8k] (little-endian), with the lane counter wrapping from 3 to 0.
REQ-019 Acceptance of lane 3 SHALL move the FSM to WRITE on the next edge.
REQ-020 In WRITE, mem_write SHALL be high for exactly one cycle with mem_address = BASE_ADDR + 4*index (32-bit wrap) and the checksum updated as checksum + word mod 2^32.
REQ-021 After WRITE, index SHALL increment; when index+1 equals word_count the FSM SHALL go to VERIFY (REQ-029) or to DONE, and otherwise to COLLECT.
REQ-022 DONE SHALL last one cycle with done=1 and then return to IDLE.
REQ-023 start SHALL be ignored while busy is high.
REQ-024 mem_address and mem_write_data SHALL hold their last values outside WRITE and VERIFY.
REQ-025 mem_write SHALL never be high outside WRITE.
REQ-026 word_count = 16383 SHALL load 16383 words, and the index SHALL never wrap within a load.

Reset
REQ-027 Assertion of reset SHALL immediately set the FSM to IDLE and busy, done, error, mem_write and byte_ready to 0; mem_address SHALL be 0, mem_write_data 0, and the lane, index and checksum counters 0.
REQ-028 A reset mid-load SHALL abort with no further writes; words already written SHALL remain in memory.

Configuration
REQ-029 With macro LOADER_VERIFY_EN defined, after the last WRITE the block SHALL read back words 0..word_count-1, driving mem_address for each on one cycle, summing mem_read_data on the following cycle, and then enter DONE; it SHALL set error=1 if the readback sum differs from the write checksum.
REQ-030 With LOADER_VERIFY_EN undefined, the VERIFY state and readback logic SHALL be absent, mem_read_data SHALL be unused, and error SHALL be constant 0.

Verification
REQ-031 The bench SHALL cover: BASE_ADDR=0, word_count=1, bytes 78,56,34,12 -> one mem_write pulse at address 0x0 with data 0x12345678; done 1 cycle later.
REQ-032 The bench SHALL cover: word_count=3 with byte_valid toggling every other cycle -> writes at 0x0, 0x4 and 0x8 only, and no byte lost or duplicated.
REQ-033 The bench SHALL cover: word_count=0 with start -> busy for 1 cycle, done pulse, and no mem_write.
REQ-034 The bench SHALL cover: reset asserted after 6 bytes of a 4-word load -> exactly one write (0x0), outputs at reset values, and a following load starting again at BASE_ADDR.
REQ-035 The bench SHALL cover, under LOADER_VERIFY_EN: 2 words, with a memory model corrupting word 1 on read -> error=1 with the done pulse; a clean rerun clears error to 0.
REQ-036 The bench SHALL cover: start pulsed while busy -> no effect on index, address or count.
